// File: rtl/ifetch_queue.sv
// rtl/ifetch_queue.sv - instruction fetch front end with prefetch FIFO and redirect flush
// Optional: define IFETCH_STALL_CNT_EN to add the saturating stall_cnt output.
module ifetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic [31:0]              imem_a,
  input  logic [31:0]              imem_rd,
  input  logic                     fetch_en,
  input  logic                     redirect_valid,
  input  logic [31:0]              redirect_pc,
  output logic                     inst_valid,
  output logic [31:0]              inst,
  output logic [31:0]              inst_pc,
  input  logic                     inst_ready,
  output logic [$clog2(DEPTH):0]   count
`ifdef IFETCH_STALL_CNT_EN
  ,
  output logic [31:0]              stall_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [31:0]   fetch_pc;
  logic [31:0]   pc_mem   [DEPTH];
  logic [31:0]   word_mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          full;
  logic          pop;
  logic          push;

  assign imem_a     = fetch_pc;
  assign full       = (count == FULL_CNT);
  assign inst_valid = (count != '0) & ~redirect_valid;
  assign pop        = inst_valid & inst_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push       = fetch_en & ~redirect_valid & (~full | pop);
  assign inst       = word_mem[rd_ptr];
  assign inst_pc    = pc_mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i]   <= '0;
        word_mem[i] <= '0;
      end
    end else if (redirect_valid) begin
      count    <= '0;
      rd_ptr   <= wr_ptr;
      fetch_pc <= {redirect_pc[31:2], 2'b00};
    end else begin
      if (push) begin
        pc_mem[wr_ptr]   <= fetch_pc;
        word_mem[wr_ptr] <= imem_rd;
        wr_ptr           <= wr_ptr + AW'(1);
        fetch_pc         <= fetch_pc + 32'd4;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !push) begin
        count <= count - CW'(1);
      end
    end
  end

`ifdef IFETCH_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (fetch_en && !redirect_valid && full && !pop && stall_cnt != 32'hFFFF_FFFF) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ifetch_queue.sv
// tb/tb_ifetch_queue.sv - self-checking bench for ifetch_queue against a queue-based reference model
module tb_ifetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] imem_a;
  logic [31:0] imem_rd;
  logic        fetch_en;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;
  logic [$clog2(DEPTH):0] count;
`ifdef IFETCH_STALL_CNT_EN
  logic [31:0] stall_cnt;
  logic [31:0] m_stall;
  logic [31:0] s_stall;
`endif

  int errors = 0;
  int checks = 0;

  // Reference model: list of fetched {pc, word} pairs plus the next fetch address.
  logic [31:0] mq_pc[$];
  logic [31:0] mq_w[$];
  logic [31:0] m_pc;

  logic        s_valid;
  logic [31:0] s_inst, s_pc, s_a, s_count;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'hE3A0_00AA;
    if (a == 32'h4) return 32'hE3A0_1055;
    return {a[15:0], ~a[31:16]} ^ 32'h5A5A_0F0F;
  endfunction

  assign imem_rd = mem_word(imem_a);

  ifetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_a         (imem_a),
    .imem_rd        (imem_rd),
    .fetch_en       (fetch_en),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_ready     (inst_ready),
    .count          (count)
`ifdef IFETCH_STALL_CNT_EN
    ,
    .stall_cnt      (stall_cnt)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Compare outputs of the current cycle against the model, then advance one clock.
  task automatic cycle();
    logic m_valid;
    @(negedge clk);
    s_valid = inst_valid;
    s_inst  = inst;
    s_pc    = inst_pc;
    s_a     = imem_a;
    s_count = 32'(count);
`ifdef IFETCH_STALL_CNT_EN
    s_stall = stall_cnt;
    check_eq("m_stall_cnt", stall_cnt, m_stall);
`endif
    m_valid = (mq_pc.size() != 0) && !redirect_valid;
    check_eq("m_imem_a", imem_a, m_pc);
    check_eq("m_count", 32'(count), 32'(mq_pc.size()));
    check_eq("m_inst_valid", 32'(inst_valid), 32'(m_valid));
    if (m_valid) begin
      check_eq("m_inst_pc", inst_pc, mq_pc[0]);
      check_eq("m_inst", inst, mq_w[0]);
    end
    @(posedge clk);
    if (reset) begin
      mq_pc.delete(); mq_w.delete();
      m_pc = RESET_PC;
`ifdef IFETCH_STALL_CNT_EN
      m_stall = 0;
`endif
    end else if (redirect_valid) begin
      mq_pc.delete(); mq_w.delete();
      m_pc = redirect_pc & 32'hFFFF_FFFC;
    end else begin
      logic do_pop, do_push;
      do_pop  = (mq_pc.size() != 0) && inst_ready;
      do_push = fetch_en && ((mq_pc.size() < DEPTH) || do_pop);
`ifdef IFETCH_STALL_CNT_EN
      if (fetch_en && mq_pc.size() == DEPTH && !do_pop && m_stall != 32'hFFFF_FFFF) m_stall++;
`endif
      if (do_pop) begin
        void'(mq_pc.pop_front()); void'(mq_w.pop_front());
      end
      if (do_push) begin
        mq_pc.push_back(m_pc);
        mq_w.push_back(mem_word(m_pc));
        m_pc = m_pc + 32'd4;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; redirect_valid = 1'b0; fetch_en = 1'b0; inst_ready = 1'b0;
    cycle();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; fetch_en = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b0;
    m_pc = RESET_PC;
`ifdef IFETCH_STALL_CNT_EN
    m_stall = 0;
`endif
    @(posedge clk); #1;

    // Reset state and first fetches
    cycle();
    check_eq("rst_valid", 32'(s_valid), 32'd0);
    check_eq("rst_inst", s_inst, 32'd0);
    check_eq("rst_inst_pc", s_pc, 32'd0);
    check_eq("rst_count", s_count, 32'd0);
    check_eq("rst_imem_a", s_a, RESET_PC);
    reset = 1'b0; fetch_en = 1'b1; inst_ready = 1'b1;
    cycle();
    check_eq("c0_imem_a", s_a, 32'h0);
    check_eq("c0_valid", 32'(s_valid), 32'd0);
    cycle();
    check_eq("c1_valid", 32'(s_valid), 32'd1);
    check_eq("c1_inst", s_inst, 32'hE3A0_00AA);
    check_eq("c1_pc", s_pc, 32'h0);
    cycle();
    check_eq("c2_inst", s_inst, 32'hE3A0_1055);
    check_eq("c2_pc", s_pc, 32'h4);
    for (int i = 0; i < 4; i++) begin
      cycle();
      check_eq("stream_pc", s_pc, 32'h8 + 32'(i) * 4);
    end

    // Backpressure
    do_reset();
    fetch_en = 1'b1; inst_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (i == 4) check_eq("bp_count4", s_count, 32'd4);
      if (i == 9) check_eq("bp_imem_a", s_a, 32'h10);
    end
    inst_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cycle();
`ifdef IFETCH_STALL_CNT_EN
      if (i == 0) check_eq("bp_stall_cnt", s_stall, 32'd6);
`endif
      check_eq("bp_valid", 32'(s_valid), 32'd1);
      check_eq("bp_pc_seq", s_pc, 32'(i) * 4);
    end

    // Redirect with three entries queued, misaligned target
    do_reset();
    fetch_en = 1'b1; inst_ready = 1'b0;
    repeat (3) cycle();
    redirect_valid = 1'b1; redirect_pc = 32'h1E6; inst_ready = 1'b1;
    cycle();
    check_eq("rd_n_count", s_count, 32'd3);
    check_eq("rd_n_valid", 32'(s_valid), 32'd0);
    redirect_valid = 1'b0;
    cycle();
    check_eq("rd_n1_imem_a", s_a, 32'h1E4);
    check_eq("rd_n1_count", s_count, 32'd0);
    check_eq("rd_n1_valid", 32'(s_valid), 32'd0);
    cycle();
    check_eq("rd_n2_valid", 32'(s_valid), 32'd1);
    check_eq("rd_n2_pc", s_pc, 32'h1E4);

    // Redirect coinciding with a ready decode
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    cycle();
    check_eq("rp_n_valid", 32'(s_valid), 32'd0);
    redirect_valid = 1'b0;
    cycle();
    cycle();
    check_eq("rp_n2_pc", s_pc, 32'h40);

    // Address wrap
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    cycle();
    redirect_valid = 1'b0;
    cycle();
    for (int i = 0; i < 3; i++) begin
      cycle();
      check_eq("wrap_pc", s_pc, 32'hFFFF_FFF8 + 32'(i) * 4);
    end

    // Reset mid-stream with two entries
    do_reset();
    fetch_en = 1'b1; inst_ready = 1'b0;
    repeat (2) cycle();
    reset = 1'b1;
    cycle();
    check_eq("mr_count_before", s_count, 32'd2);
    reset = 1'b0; inst_ready = 1'b1;
    cycle();
    check_eq("mr_valid", 32'(s_valid), 32'd0);
    check_eq("mr_count", s_count, 32'd0);
    check_eq("mr_imem_a", s_a, RESET_PC);
    cycle();
    check_eq("mr_restart_pc", s_pc, RESET_PC);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      reset          = ($urandom_range(199) == 0);
      fetch_en       = ($urandom_range(9) < 8);
      inst_ready     = ($urandom_range(9) < 6);
      redirect_valid = ($urandom_range(19) == 0);
      redirect_pc    = $urandom();
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ifetch_queue.md
# ifetch_queue

Instruction fetch front end for the single-cycle ARM core. It is the initiator side of the instruction-memory read interface: it drives word addresses into the combinational instruction ROM/RAM and captures the returned words with their PCs. Those entries go into a small prefetch FIFO, which hands instructions to decode over a valid/ready handshake. It supports redirect (branch/exception) with a full flush, and sustains one instruction per cycle.

## Interface
- DEPTH, 4, FIFO entries; power of two, ≥2
- RESET_PC, 32'h0000_0000, first fetch address after reset; bits [1:0] must be 0
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- imem_a  out  32  fetch address to instruction memory; always word aligned
- imem_rd  in  32  instruction word; combinational function of imem_a in the same cycle
- fetch_en  in  1  1 = fetching allowed; 0 = hold fetch_pc, no push
- redirect_valid  in  1  flush and restart fetch at redirect_pc
- redirect_pc  in  32  new fetch target; bits [1:0] ignored (forced 0)
- inst_valid  out  1  FIFO head holds a valid instruction
- inst  out  32  instruction word at FIFO head
- inst_pc  out  32  address of inst
- inst_ready  in  1  decode accepts head this cycle
- count  out  $clog2(DEPTH)+1  occupied entries, 0..DEPTH

## Operation
- Registers: fetch_pc (32), storage[DEPTH] of {pc, word}, rd_ptr, wr_ptr, count.
- imem_a = fetch_pc, combinationally, every cycle.
- pop = inst_valid & inst_ready.
- push = fetch_en & ~redirect_valid & (count < DEPTH | pop).
- On push: storage[wr_ptr] <= {fetch_pc, imem_rd}; wr_ptr++; fetch_pc <= fetch_pc + 4. The add wraps 32'hFFFF_FFFC → 0.
- On pop: rd_ptr++. Count updates as +push −pop; simultaneous push and pop leave count unchanged.
- Full (count == DEPTH): push is allowed only when pop occurs in the same cycle. Otherwise fetch_pc holds.
- Empty: inst_valid = 0; inst and inst_pc show storage[rd_ptr], but their value carries no meaning.
- inst_valid = (count != 0) & ~redirect_valid. Decode cannot consume during a redirect cycle.
- Redirect (priority over push and pop): count <= 0, rd_ptr <= wr_ptr, fetch_pc <= {redirect_pc[31:2], 2'b00}. Nothing is pushed or popped that cycle.
- Pointers wrap modulo DEPTH.
- Reset (priority over everything, mid-operation included):
  - fetch_pc <= RESET_PC; pointers, count <= 0; all storage <= 0.
  - Outputs after reset: imem_a = RESET_PC, inst_valid = 0, inst = 0, inst_pc = 0, count = 0.

## Timing
- Cycle 0 is the first cycle with reset low and fetch_en = 1. The edge ending cycle 0 pushes RESET_PC. In cycle 1, inst_valid = 1 and inst = mem[RESET_PC>>2].
- Steady state: one push and one pop per cycle. Fetch-to-decode latency is 1 cycle.
- Redirect asserted in cycle n:
  - Cycle n: inst_valid = 0.
  - Cycle n+1: imem_a = target, inst_valid = 0.
  - Cycle n+2: inst_valid = 1, inst_pc = target.
- inst_ready low with the FIFO full: fetch stalls. Fetch resumes in the same cycle inst_ready returns high, with no lost or duplicated PC.
- fetch_en low: imem_a is stable and the FIFO drains normally.

## Configuration
- IFETCH_STALL_CNT_EN defined:
  - Adds output stall_cnt (32 bits), reset to 0.
  - Increments on every cycle with fetch_en & ~redirect_valid & count == DEPTH & ~pop.
  - Saturates at 32'hFFFF_FFFF.
- IFETCH_STALL_CNT_EN not defined: port and counter are absent; behaviour is otherwise identical.

## Test plan
- Reset release, program E3A000AA at word 0 and E3A01055 at word 1, inst_ready = 1:
  - Cycle 1: inst = E3A000AA, inst_pc = 0.
  - Cycle 2: inst = E3A01055, inst_pc = 4.
  - One instruction per cycle thereafter.
- Backpressure, DEPTH = 4, inst_ready = 0 for 10 cycles:
  - count reaches 4 at cycle 4; imem_a holds 0x10.
  - With IFETCH_STALL_CNT_EN, stall_cnt = 6.
  - After inst_ready = 1, inst_pc sequence is 0, 4, 8, C, 10 with no gaps.
- Redirect with FIFO holding 3 entries, redirect_pc = 0x1E6 (misaligned low bits):
  - Cycle n+1: imem_a = 0x1E4, count = 0.
  - Cycle n+2: inst_pc = 0x1E4.
  - None of the flushed entries is ever presented.
- Redirect and pop in the same cycle, with redirect_pc = 0x40: the head is not consumed, the FIFO is flushed, and the next presented inst_pc = 0x40.
- Wrap: redirect_pc = 0xFFFF_FFF8 → presented PCs FFFF_FFF8, FFFF_FFFC, 0000_0000.
- Reset asserted mid-stream with count = 2:
  - Next cycle: inst_valid = 0, count = 0, imem_a = RESET_PC.
  - Fetch restarts from RESET_PC after release.
